// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared widths and request record for the memory responder
package mc_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int COUNT_W    = 32;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/mem_ctrl_responder_if.sv
// rtl/mem_ctrl_responder_if.sv - request/return bus between initiator and responder
interface mem_ctrl_responder_if import mc_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = COUNT_W
);

  logic [ADDR_W-1:0] wr_address;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_ret_address;
  logic              wr_ret_ack;
  logic [ADDR_W-1:0] rd_address;
  logic              rd_en;
  logic [DATA_W-1:0] rd_ret_data;
  logic [ADDR_W-1:0] rd_ret_address;
  logic              rd_ret_ack;
  logic [CNT_W-1:0]  wr_count;
  logic [CNT_W-1:0]  rd_count;

  modport master (
    output wr_address, wr_en, wr_data, rd_address, rd_en,
    input  wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack,
    input  wr_count, rd_count
  );

  modport slave (
    input  wr_address, wr_en, wr_data, rd_address, rd_en,
    output wr_ret_address, wr_ret_ack, rd_ret_data, rd_ret_address, rd_ret_ack,
    output wr_count, rd_count
  );

endinterface

// File: rtl/mc_delay_line.sv
// rtl/mc_delay_line.sv - fixed-depth {valid,data} shift; reset clears only the valid bits
module mc_delay_line import mc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload needs no reset: it is only observed alongside its valid bit.
  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mem_ctrl_responder.sv
// rtl/mem_ctrl_responder.sv - fixed-latency memory responder: store, write-first bypass, counters
module mem_ctrl_responder import mc_pkg::*; #(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_AW     = 10,
  parameter int WR_LATENCY = 4,
  parameter int RD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_ctrl_responder_if.slave  bus
);

  localparam int WR_W = ADDR_W + DATA_W;

  logic              wr_pipe_valid;
  logic [WR_W-1:0]   wr_pipe_data;
  logic              rd_pipe_valid;
  logic [ADDR_W-1:0] rd_pipe_addr;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_wdata;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;

  logic [DATA_W-1:0] mem_q [2**MEM_AW];

  logic               wr_ack_q, rd_ack_q;
  logic [ADDR_W-1:0]  wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [COUNT_W-1:0] wr_count_q, rd_count_q;

  mc_delay_line #(.WIDTH(WR_W), .DEPTH(WR_LATENCY)) u_wr_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.wr_en),
    .in_data   ({bus.wr_address, bus.wr_data}),
    .out_valid (wr_pipe_valid),
    .out_data  (wr_pipe_data)
  );

  mc_delay_line #(.WIDTH(ADDR_W), .DEPTH(RD_LATENCY)) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.rd_en),
    .in_data   (bus.rd_address),
    .out_valid (rd_pipe_valid),
    .out_data  (rd_pipe_addr)
  );

  assign wr_addr  = wr_pipe_data[WR_W-1 -: ADDR_W];
  assign wr_wdata = wr_pipe_data[DATA_W-1:0];
  assign wr_idx   = wr_addr[MEM_AW-1:0];
  assign rd_idx   = rd_pipe_addr[MEM_AW-1:0];

  // A write retiring on the same edge must be seen by the read retiring with it.
  always_comb begin
    rd_data_d = mem_q[rd_idx];
    if (wr_pipe_valid && (wr_idx == rd_idx)) begin
      rd_data_d = wr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_pipe_valid) begin
      mem_q[wr_idx] <= wr_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      wr_ack_q <= wr_pipe_valid;
      rd_ack_q <= rd_pipe_valid;
      if (wr_pipe_valid) begin
        wr_addr_q  <= wr_addr;
        wr_count_q <= wr_count_q + 1'b1;
      end
      if (rd_pipe_valid) begin
        rd_addr_q  <= rd_pipe_addr;
        rd_data_q  <= rd_data_d;
        rd_count_q <= rd_count_q + 1'b1;
      end
    end
  end

  assign bus.wr_ret_ack     = wr_ack_q;
  assign bus.wr_ret_address = wr_addr_q;
  assign bus.rd_ret_ack     = rd_ack_q;
  assign bus.rd_ret_address = rd_addr_q;
  assign bus.rd_ret_data    = rd_data_q;
  assign bus.wr_count       = wr_count_q;
  assign bus.rd_count       = rd_count_q;

endmodule

// File: tb/tb_mem_ctrl_responder.sv
// tb/tb_mem_ctrl_responder.sv - directed and random checks against a timestamped queue model
module tb_mem_ctrl_responder;
  import mc_pkg::*;

  localparam int MEM_AW = 10;
  localparam int WL     = 4;
  localparam int RL     = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_ctrl_responder_if #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W), .CNT_W(COUNT_W)) bus ();

  mem_ctrl_responder #(
    .ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W), .MEM_AW(MEM_AW),
    .WR_LATENCY(WL), .RD_LATENCY(RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int   due;
    req_t req;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  logic [DEF_DATA_W-1:0] mem_m [int];

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  logic                  exp_wack = 1'b0;
  logic                  exp_rack = 1'b0;
  logic [DEF_ADDR_W-1:0] exp_waddr = '0;
  logic [DEF_ADDR_W-1:0] exp_raddr = '0;
  logic [DEF_DATA_W-1:0] exp_rdata = '0;
  bit                    exp_rknown = 1'b0;
  logic [31:0]           exp_wcnt = '0;
  logic [31:0]           exp_rcnt = '0;

  function automatic int idx_of(input logic [DEF_ADDR_W-1:0] a);
    return int'(a) % (1 << MEM_AW);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                       input bit re, input logic [15:0] ra);
    bus.wr_en      = we;
    bus.wr_address = wa;
    bus.wr_data    = wd;
    bus.rd_en      = re;
    bus.rd_address = ra;
  endtask

  // One clock: advance the model by what the edge samples, then compare every output.
  task automatic tick();
    bit   rst_s, we, re;
    req_t wreq, rreq;
    ev_t  e;
    rst_s = reset;
    we    = bus.wr_en;
    re    = bus.rd_en;
    wreq  = '{valid: 1'b1, addr: bus.wr_address, data: bus.wr_data};
    rreq  = '{valid: 1'b1, addr: bus.rd_address, data: '0};
    @(posedge clk);
    cyc++;
    if (rst_s) begin
      wq.delete();
      rq.delete();
      exp_wack = 0; exp_rack = 0; exp_waddr = '0; exp_raddr = '0;
      exp_rdata = '0; exp_rknown = 1; exp_wcnt = '0; exp_rcnt = '0;
    end else begin
      exp_wack = 0;
      exp_rack = 0;
      if (wq.size() > 0 && wq[0].due == cyc) begin
        e = wq.pop_front();
        mem_m[idx_of(e.req.addr)] = e.req.data;
        exp_wack  = 1;
        exp_waddr = e.req.addr;
        exp_wcnt++;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        exp_rack  = 1;
        exp_raddr = e.req.addr;
        exp_rcnt++;
        exp_rknown = mem_m.exists(idx_of(e.req.addr));
        if (exp_rknown) exp_rdata = mem_m[idx_of(e.req.addr)];
      end
      if (we) wq.push_back('{due: cyc + WL, req: wreq});
      if (re) rq.push_back('{due: cyc + RL, req: rreq});
    end
    #1;
    chk("wr_ret_ack", 32'(bus.wr_ret_ack), 32'(exp_wack));
    chk("wr_ret_address", 32'(bus.wr_ret_address), 32'(exp_waddr));
    chk("rd_ret_ack", 32'(bus.rd_ret_ack), 32'(exp_rack));
    chk("rd_ret_address", 32'(bus.rd_ret_address), 32'(exp_raddr));
    if (exp_rknown) chk("rd_ret_data", 32'(bus.rd_ret_data), 32'(exp_rdata));
    chk("wr_count", bus.wr_count, exp_wcnt);
    chk("rd_count", bus.rd_count, exp_rcnt);
  endtask

  task automatic idle(input int n);
    drive(0, '0, '0, 0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, '0);
    tick();
    tick();
    chk("reset_wr_count", bus.wr_count, 32'd0);
    chk("reset_rd_ack", 32'(bus.rd_ret_ack), 32'd0);
    reset = 1'b0;

    // 1: write retires exactly four edges after acceptance
    drive(1, 16'h0005, 16'hBEEF, 0, '0);
    tick();
    idle(3);
    chk("t1_early_ack", 32'(bus.wr_ret_ack), 32'd0);
    tick();
    chk("t1_ack", 32'(bus.wr_ret_ack), 32'd1);
    chk("t1_addr", 32'(bus.wr_ret_address), 32'h0005);
    chk("t1_count", bus.wr_count, 32'd1);
    tick();
    chk("t1_pulse", 32'(bus.wr_ret_ack), 32'd0);
    chk("t1_hold_addr", 32'(bus.wr_ret_address), 32'h0005);

    // 2: read back
    drive(0, '0, '0, 1, 16'h0005);
    tick();
    idle(3);
    tick();
    chk("t2_ack", 32'(bus.rd_ret_ack), 32'd1);
    chk("t2_data", 32'(bus.rd_ret_data), 32'hBEEF);
    chk("t2_addr", 32'(bus.rd_ret_address), 32'h0005);

    // 3: same-edge read and write retire -> bypass
    drive(1, 16'h0010, 16'h1234, 1, 16'h0010);
    tick();
    idle(4);
    chk("t3_bypass", 32'(bus.rd_ret_data), 32'h1234);

    // 4: streaming
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1, 16'(i), 16'(i) ^ 16'h5A00, 1, 16'(i));
      tick();
    end
    idle(6);
    chk("t4_wr_count", bus.wr_count, 32'd100);
    chk("t4_rd_count", bus.rd_count, 32'd100);
    chk("t4_last_data", 32'(bus.rd_ret_data), 32'h5A63);

    // 5: reset flushes in-flight writes; stored word survives
    drive(1, 16'h0030, 16'h7777, 0, '0);
    tick();
    idle(6);
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 16'h0030, 16'(i), 0, '0);
      tick();
    end
    idle(1);
    drive(1, 16'h0030, 16'h0009, 0, '0);
    do_reset();
    idle(10);
    chk("t5_wr_count", bus.wr_count, 32'd0);
    chk("t5_rd_count", bus.rd_count, 32'd0);
    drive(0, '0, '0, 1, 16'h0030);
    tick();
    idle(4);
    chk("t5_preserved", 32'(bus.rd_ret_data), 32'h7777);

    // 6: aliasing above MEM_AW
    drive(1, 16'h0407, 16'hAAAA, 0, '0);
    tick();
    idle(5);
    drive(0, '0, '0, 1, 16'h0007);
    tick();
    idle(4);
    chk("t6_data", 32'(bus.rd_ret_data), 32'hAAAA);
    chk("t6_addr", 32'(bus.rd_ret_address), 32'h0007);

    // random traffic with aliasing, hazards and occasional resets
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1,
            16'(($urandom & 32'hFC00) | ($urandom % 24)), 16'($urandom),
            $urandom_range(0, 1) == 1,
            16'(($urandom & 32'hFC00) | ($urandom % 24)));
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
